axi_adc_reg_arbiter: RTL

- Shares the single AXI4-Lite slave port of the AXI_ADC register bank (4 x 32-bit registers) between N_REQ on-chip requesters, e.g. the boot configuration FSM and the TCP command path.
- Accepts simple request/response transactions, arbitrates them round-robin and issues one AXI4-Lite transaction at a time.
- Returns the read data and the response code to the requester that issued the transaction.
- Sits between the requesters and the S00_AXI port of AXI_ADC, in the same clock domain.

---
 rtl/axi_adc_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/axi_adc_reg_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axi_adc_arb_pkg.sv
// Shared types and constants for the AXI_ADC register-port arbiter.
// Also used by the data-path DMA arbiter through rr_arbiter.
package axi_adc_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR        = 3'd1,
    ST_WR_B      = 3'd2,
    ST_RD_AR     = 3'd3,
    ST_RD_R      = 3'd4,
    ST_LOCAL_ERR = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int DEFAULT_N_REGS = 4;

  // Byte address to 32-bit word index; callers zero-extend narrower addresses.
  function automatic int unsigned word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer advances past the grantee whenever a grant is taken.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_accept,
  output logic [N_REQ-1:0] o_grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic          w_found;
  int            w_idx;

  always_comb begin
    o_grant = '0;
    w_gidx  = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && i_req[w_idx[PW-1:0]]) begin
        w_found                 = 1'b1;
        o_grant[w_idx[PW-1:0]]  = 1'b1;
        w_gidx                  = w_idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_accept && w_found) begin
      r_ptr <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + PW'(1);
    end
  end

endmodule

// File: rtl/axi_adc_reg_arbiter.sv
// Shares the AXI4-Lite slave port of the AXI_ADC register bank between
// N_REQ requesters, one transaction at a time, round-robin.
module axi_adc_reg_arbiter
  import axi_adc_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 4,
  parameter int N_REGS = DEFAULT_N_REGS
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*32-1:0]     req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_W-1:0]       M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [31:0]             M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_W-1:0]       M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [31:0]             M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [ADDR_W-3:0]   r_word;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [1:0]          r_resp;
  logic                r_aw_done;
  logic                r_w_done;

  logic [N_REQ-1:0]    w_grant;
  logic                w_idle;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic                w_oor;
  logic                w_aw_hs;
  logic                w_w_hs;

  assign w_idle = (r_state == ST_IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_clk    (ACLK),
    .i_rst    (ARESET),
    .i_req    (req_valid),
    .i_accept (w_idle),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  assign w_oor   = word_index(32'(w_sel_addr)) >= $unsigned(N_REGS);
  assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  assign req_ready = w_idle ? w_grant : '0;
  assign rsp_valid = (r_state == ST_RESP) ? r_grant : '0;
  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;

  // The bus address is always word-aligned, whatever the requester sent.
  assign M_AXI_AWADDR  = {r_word, 2'b00};
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (r_state == ST_WR) && !r_aw_done;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = (r_state == ST_WR) && !r_w_done;
  assign M_AXI_BREADY  = (r_state == ST_WR_B);
  assign M_AXI_ARADDR  = {r_word, 2'b00};
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (r_state == ST_RD_AR);
  assign M_AXI_RREADY  = (r_state == ST_RD_R);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_word    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_resp    <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (|req_valid) begin
            r_grant <= w_grant;
            r_word  <= w_sel_addr[ADDR_W-1:2];
            r_wdata <= w_sel_wdata;
            if (w_oor)         r_state <= ST_LOCAL_ERR;
            else if (w_sel_we) r_state <= ST_WR;
            else               r_state <= ST_RD_AR;
          end
        end
        // AW and W complete independently, in either order or together.
        ST_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_state <= ST_WR_B;
        end
        ST_WR_B: begin
          if (M_AXI_BVALID) begin
            r_resp  <= M_AXI_BRESP;
            r_rdata <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_RD_AR: begin
          if (M_AXI_ARREADY) r_state <= ST_RD_R;
        end
        ST_RD_R: begin
          if (M_AXI_RVALID) begin
            r_resp  <= M_AXI_RRESP;
            r_rdata <= M_AXI_RDATA;
            r_state <= ST_RESP;
          end
        end
        ST_LOCAL_ERR: begin
          r_resp  <= RESP_DECERR;
          r_rdata <= '0;
          r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
